// File: rtl/quick_spi_pkg.sv
// QuickSPI shared types: controller states and operation encodings.
// Optional build macro QUICK_SPI_LSB_FIRST_EN is consumed by quick_spi_param.
package quick_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD
  } state_e;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

endpackage

// File: rtl/quick_spi_sclk_gen.sv
// QuickSPI SCLK generator: half-period divider with leading/trailing strobes.
// Counter and phase sit at zero whenever the generator is disabled.
module quick_spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic cpol,
  output logic lead,
  output logic trail,
  output logic sclk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          phase_q;
  logic          half;

  assign half  = en && (cnt_q == LAST);
  assign lead  = half && !phase_q;
  assign trail = half && phase_q;
  assign sclk  = cpol ^ phase_q;

  // divide clk into SCLK half-periods; phase 1 is the non-idle level
  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (half) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/quick_spi_param.sv
// QuickSPI parametrised SPI master, per-transaction CPOL/CPHA and read/write.
// Define QUICK_SPI_LSB_FIRST_EN to shift and capture LSB first.
module quick_spi_param
  import quick_spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SLAVES     = 2,
  parameter int SLAVE_W    = (SLAVES > 1) ? $clog2(SLAVES) : 1,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_transaction,
  input  logic [SLAVE_W-1:0]    slave,
  input  logic                  operation,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DATA_WIDTH-1:0] outgoing_data,
  output logic [DATA_WIDTH-1:0] incoming_data,
  output logic                  busy,
  output logic                  end_of_transaction,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  sclk,
  output logic [SLAVES-1:0]     ss_n
);

`ifdef QUICK_SPI_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         bit_q;
  logic [DATA_WIDTH-1:0] tx_q, rx_q, in_q;
  logic [DATA_WIDTH-1:0] tx_shift, rx_next;
  logic [SLAVES-1:0]     ss_q, sel_n;
  logic                  op_q, cpol_q, cpha_q;
  logic                  mosi_q, busy_q, eot_q, idle_q;
  logic                  accept, phase_done, hold_done;
  logic                  lead, trail, gen_sclk;

  function automatic logic head(input logic [DATA_WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[DATA_WIDTH-1];
  endfunction

  assign accept = (state_q == IDLE) && !busy_q && start_transaction
                  && (int'(slave) < SLAVES);
  assign phase_done = (cnt_q == LAST);
  assign hold_done  = (state_q == HOLD) && phase_done;

  assign tx_shift = LSB_FIRST ? (tx_q >> 1) : (tx_q << 1);
  assign rx_next  = LSB_FIRST ? {miso, rx_q[DATA_WIDTH-1:1]}
                              : {rx_q[DATA_WIDTH-2:0], miso};

  quick_spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (state_q == TRANSFER),
    .cpol   (cpol_q),
    .lead   (lead),
    .trail  (trail),
    .sclk   (gen_sclk)
  );

  // decode requested slave index into an active-low select pattern
  always_comb begin
    sel_n = '1;
    for (int i = 0; i < SLAVES; i++) begin
      if (int'(slave) == i) sel_n[i] = 1'b0;
    end
  end

  // next-state logic for the transaction sequencer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = SETUP;
      SETUP:    if (phase_done) state_d = TRANSFER;
      TRANSFER: if (trail && bit_q == LAST_BIT) state_d = HOLD;
      HOLD:     if (phase_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // setup/hold cycle counter and transferred-bit counter
  always_ff @(posedge clk) begin
    if (!reset_n || state_d != state_q) cnt_q <= '0;
    else                                cnt_q <= cnt_q + 1'b1;
    if (!reset_n || accept) bit_q <= '0;
    else if (trail)         bit_q <= bit_q + 1'b1;
  end

  // latch request, shift data on SCLK strobes, drive selects and status
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q   <= OP_WRITE;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      tx_q   <= '0;
      rx_q   <= '0;
      in_q   <= '0;
      ss_q   <= '1;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
      eot_q  <= 1'b0;
      idle_q <= 1'b0;
    end else begin
      eot_q  <= hold_done;
      idle_q <= cpol;
      if (eot_q) busy_q <= 1'b0;
      if (accept) begin
        busy_q <= 1'b1;
        op_q   <= operation;
        cpol_q <= cpol;
        cpha_q <= cpha;
        tx_q   <= outgoing_data;
        ss_q   <= sel_n;
        mosi_q <= (operation == OP_WRITE && !cpha) ? head(outgoing_data)
                                                   : 1'b0;
      end
      if (lead) begin
        if (!cpha_q) begin
          rx_q <= rx_next;
        end else if (op_q == OP_WRITE) begin
          mosi_q <= head(tx_q);
          tx_q   <= tx_shift;
        end
      end
      if (trail) begin
        if (cpha_q) begin
          rx_q <= rx_next;
        end else if (op_q == OP_WRITE) begin
          mosi_q <= head(tx_shift);
          tx_q   <= tx_shift;
        end
      end
      if (hold_done) begin
        ss_q   <= '1;
        mosi_q <= 1'b0;
        if (op_q == OP_READ) in_q <= rx_q;
      end
    end
  end

  assign incoming_data      = in_q;
  assign busy               = busy_q;
  assign end_of_transaction = eot_q;
  assign mosi               = mosi_q;
  assign sclk               = busy_q ? gen_sclk : idle_q;
  assign ss_n               = ss_q;

endmodule
